// File: rtl/timer_apb_regs.sv
// APB register block for the 8-bit timer: TDR, TCR, sticky TSR flags and read-only TCNT.
// Define APB_WAIT_STATE_EN to insert one wait cycle in every access phase.
module timer_apb_regs #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic              pclk,
  input  logic              preset,
  input  logic              psel,
  input  logic              penable,
  input  logic              pwrite,
  input  logic [ADDR_W-1:0] paddr,
  input  logic [DATA_W-1:0] pwdata,
  output logic [DATA_W-1:0] prdata,
  output logic              pready,
  output logic              pslverr,
  output logic [7:0]        tdr_o,
  output logic              load_o,
  output logic              dw_o,
  output logic              en_o,
  output logic [1:0]        cks_o,
  input  logic              ovf_set_i,
  input  logic              udf_set_i,
  input  logic [7:0]        tcnt_i
);

  // IDLE doubles as the setup phase: a setup cycle is recognised there combinationally,
  // so ACCESS lines up with the bus access phase and a transfer takes two cycles.
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
`ifdef APB_WAIT_STATE_EN
  localparam logic [1:0] ST_WAIT   = 2'd2;
`endif

  localparam logic [7:0] TCR_MASK = 8'hB3;

  logic [1:0] state;
  logic [1:0] state_nxt;
  logic [7:0] tdr;
  logic [7:0] tcr;
  logic       ovf;
  logic       udf;
  logic       xfer;
  logic       addr_err;
  logic       wr_ok;
  logic       wr_tsr;
  logic [1:0] addr_lo;
  logic [7:0] rd_mux;

  assign addr_lo  = paddr[1:0];
  assign addr_err = (|paddr[ADDR_W-1:2]) | (pwrite & (addr_lo == 2'd3));
  assign xfer     = psel & penable & pready;
  assign wr_ok    = xfer & pwrite & ~addr_err;
  assign wr_tsr   = wr_ok & (addr_lo == 2'd2);

  always_comb begin
    state_nxt = state;
    pready    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (psel && !penable) state_nxt = ST_ACCESS;
      end
`ifdef APB_WAIT_STATE_EN
      ST_ACCESS: begin
        state_nxt = psel ? ST_WAIT : ST_IDLE;
      end
      ST_WAIT: begin
        pready    = 1'b1;
        state_nxt = (psel && !penable) ? ST_ACCESS : ST_IDLE;
      end
`else
      ST_ACCESS: begin
        pready    = 1'b1;
        state_nxt = (psel && !penable) ? ST_ACCESS : ST_IDLE;
      end
`endif
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Flags: a set pulse overrides a same-cycle write-0 clear.
  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      state <= ST_IDLE;
      tdr   <= 8'h00;
      tcr   <= 8'h00;
      ovf   <= 1'b0;
      udf   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (wr_ok && addr_lo == 2'd0) tdr <= pwdata;
      if (wr_ok && addr_lo == 2'd1) tcr <= pwdata & TCR_MASK;
      ovf <= ovf_set_i | (ovf & ~(wr_tsr & ~pwdata[0]));
      udf <= udf_set_i | (udf & ~(wr_tsr & ~pwdata[1]));
    end
  end

  always_comb begin
    rd_mux = 8'h00;
    if (xfer && !pwrite && !addr_err) begin
      case (addr_lo)
        2'd0:    rd_mux = tdr;
        2'd1:    rd_mux = tcr;
        2'd2:    rd_mux = {6'b000000, udf, ovf};
        default: rd_mux = tcnt_i;
      endcase
    end
  end

  assign prdata  = rd_mux;
  assign pslverr = xfer & addr_err;
  assign tdr_o   = tdr;
  assign load_o  = tcr[7];
  assign dw_o    = tcr[5];
  assign en_o    = tcr[4];
  assign cks_o   = tcr[1:0];

endmodule

// File: tb/tb_timer_apb_regs.sv
// Self-checking bench for timer_apb_regs: directed scenarios plus random transfers
// checked against a register-level model of the timer's programmer's view.
module tb_timer_apb_regs;

`ifdef APB_WAIT_STATE_EN
  localparam int EXP_CYC = 2;
`else
  localparam int EXP_CYC = 1;
`endif

  logic       pclk = 1'b0;
  logic       preset = 1'b1;
  logic       psel = 1'b0;
  logic       penable = 1'b0;
  logic       pwrite = 1'b0;
  logic [7:0] paddr = 8'h00;
  logic [7:0] pwdata = 8'h00;
  logic [7:0] prdata;
  logic       pready;
  logic       pslverr;
  logic [7:0] tdr_o;
  logic       load_o;
  logic       dw_o;
  logic       en_o;
  logic [1:0] cks_o;
  logic       ovf_set_i = 1'b0;
  logic       udf_set_i = 1'b0;
  logic [7:0] tcnt_i = 8'h00;

  int checks = 0;
  int failures = 0;

  logic [7:0] m_tdr = 8'h00;
  logic [7:0] m_tcr = 8'h00;
  logic       m_ovf = 1'b0;
  logic       m_udf = 1'b0;

  timer_apb_regs dut (
    .pclk(pclk), .preset(preset), .psel(psel), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .prdata(prdata), .pready(pready), .pslverr(pslverr),
    .tdr_o(tdr_o), .load_o(load_o), .dw_o(dw_o), .en_o(en_o), .cks_o(cks_o),
    .ovf_set_i(ovf_set_i), .udf_set_i(udf_set_i), .tcnt_i(tcnt_i)
  );

  always #5 pclk = ~pclk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  function automatic bit m_err(input bit wr, input logic [7:0] a);
    return (a > 8'd3) || (wr && a == 8'd3);
  endfunction

  function automatic logic [7:0] m_read(input logic [7:0] a);
    case (a)
      8'd0:    return m_tdr;
      8'd1:    return m_tcr;
      8'd2:    return {6'b000000, m_udf, m_ovf};
      8'd3:    return tcnt_i;
      default: return 8'h00;
    endcase
  endfunction

  task automatic m_commit(input bit wr, input logic [7:0] a, input logic [7:0] wd,
                          input bit povf, input bit pudf);
    if (wr && !m_err(wr, a)) begin
      case (a)
        8'd0: m_tdr = wd;
        8'd1: m_tcr = wd & 8'hB3;
        8'd2: begin
          m_ovf = m_ovf & wd[0];
          m_udf = m_udf & wd[1];
        end
        default: ;
      endcase
    end
    if (povf) m_ovf = 1'b1;
    if (pudf) m_udf = 1'b1;
  endtask

  // One APB transfer; optional core pulses land in the completing cycle. cyc=-1 on timeout.
  task automatic applyStimulus(input bit wr, input logic [7:0] a, input logic [7:0] wd,
                               input bit povf, input bit pudf,
                               output logic [7:0] rd, output logic err, output int cyc);
    @(negedge pclk);
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = wd;
    @(negedge pclk);
    penable = 1'b1;
    cyc = 1;
    #1;
    while (pready !== 1'b1 && cyc < 6) begin
      @(negedge pclk);
      cyc++;
      #1;
    end
    if (pready !== 1'b1) cyc = -1;
    rd = prdata;
    err = pslverr;
    ovf_set_i = povf;
    udf_set_i = pudf;
    @(posedge pclk);
    #1;
    ovf_set_i = 1'b0;
    udf_set_i = 1'b0;
    m_commit(wr, a, wd, povf, pudf);
  endtask

  task automatic bus_idle();
    @(negedge pclk);
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  task automatic test_reset();
    preset = 1'b1;
    repeat (2) @(negedge pclk);
    checks++;
    if ({pready, pslverr, prdata} !== 10'h000) begin
      failures++;
      $display("[TB] FAIL reset_bus: got %h expected 000", {pready, pslverr, prdata});
    end
    checks++;
    if ({tdr_o, load_o, dw_o, en_o, cks_o} !== 13'h0000) begin
      failures++;
      $display("[TB] FAIL reset_ctrl: got %h expected 0000", {tdr_o, load_o, dw_o, en_o, cks_o});
    end
    preset = 1'b0;
  endtask

  task automatic test_tdr();
    logic [7:0] rd; logic err; int cyc;
    applyStimulus(1'b1, 8'h00, 8'h05, 1'b0, 1'b0, rd, err, cyc);
    checks++;
    if (err !== 1'b0 || cyc != EXP_CYC) begin
      failures++;
      $display("[TB] FAIL tdr_write: err=%b cyc=%0d expected err=0 cyc=%0d", err, cyc, EXP_CYC);
    end
    applyStimulus(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, rd, err, cyc);
    checks++;
    if (rd !== 8'h05 || err !== 1'b0 || tdr_o !== 8'h05) begin
      failures++;
      $display("[TB] FAIL tdr_read: rd=%h err=%b tdr_o=%h expected 05 0 05", rd, err, tdr_o);
    end
  endtask

  task automatic test_tcr();
    logic [7:0] rd; logic err; int cyc;
    applyStimulus(1'b1, 8'h01, 8'h80, 1'b0, 1'b0, rd, err, cyc);
    checks++;
    if (load_o !== 1'b1) begin
      failures++;
      $display("[TB] FAIL tcr_load_set: got %b expected 1", load_o);
    end
    applyStimulus(1'b1, 8'h01, 8'h30, 1'b0, 1'b0, rd, err, cyc);
    checks++;
    if ({load_o, dw_o, en_o, cks_o} !== 5'b01100) begin
      failures++;
      $display("[TB] FAIL tcr_ctrl: got %b expected 01100", {load_o, dw_o, en_o, cks_o});
    end
    applyStimulus(1'b0, 8'h01, 8'h00, 1'b0, 1'b0, rd, err, cyc);
    checks++;
    if (rd !== 8'h30) begin
      failures++;
      $display("[TB] FAIL tcr_read: got %h expected 30", rd);
    end
    applyStimulus(1'b1, 8'h01, 8'hFF, 1'b0, 1'b0, rd, err, cyc);
    applyStimulus(1'b0, 8'h01, 8'h00, 1'b0, 1'b0, rd, err, cyc);
    checks++;
    if (rd !== 8'hB3 || cks_o !== 2'b11) begin
      failures++;
      $display("[TB] FAIL tcr_reserved: rd=%h cks=%b expected B3 11", rd, cks_o);
    end
  endtask

  task automatic test_tsr();
    logic [7:0] rd; logic err; int cyc;
    @(negedge pclk); udf_set_i = 1'b1;
    @(negedge pclk); udf_set_i = 1'b0;
    m_udf = 1'b1;
    applyStimulus(1'b0, 8'h02, 8'h00, 1'b0, 1'b0, rd, err, cyc);
    checks++;
    if (rd !== 8'h02) begin
      failures++;
      $display("[TB] FAIL tsr_udf: got %h expected 02", rd);
    end
    applyStimulus(1'b1, 8'h02, 8'h00, 1'b0, 1'b0, rd, err, cyc);
    applyStimulus(1'b0, 8'h02, 8'h00, 1'b0, 1'b0, rd, err, cyc);
    checks++;
    if (rd !== 8'h00) begin
      failures++;
      $display("[TB] FAIL tsr_clear: got %h expected 00", rd);
    end
    applyStimulus(1'b1, 8'h02, 8'h00, 1'b1, 1'b0, rd, err, cyc);
    applyStimulus(1'b0, 8'h02, 8'h00, 1'b0, 1'b0, rd, err, cyc);
    checks++;
    if (rd !== 8'h01) begin
      failures++;
      $display("[TB] FAIL tsr_set_wins: got %h expected 01", rd);
    end
    applyStimulus(1'b1, 8'h02, 8'hFF, 1'b0, 1'b1, rd, err, cyc);
    applyStimulus(1'b1, 8'h02, 8'hFE, 1'b0, 1'b0, rd, err, cyc);
    applyStimulus(1'b0, 8'h02, 8'h00, 1'b0, 1'b0, rd, err, cyc);
    checks++;
    if (rd !== 8'h02) begin
      failures++;
      $display("[TB] FAIL tsr_write1_keeps: got %h expected 02", rd);
    end
  endtask

  task automatic test_errors();
    logic [7:0] rd; logic err; int cyc;
    applyStimulus(1'b0, 8'h05, 8'h00, 1'b0, 1'b0, rd, err, cyc);
    checks++;
    if (err !== 1'b1 || rd !== 8'h00) begin
      failures++;
      $display("[TB] FAIL err_read_05: err=%b rd=%h expected 1 00", err, rd);
    end
    tcnt_i = 8'h3C;
    applyStimulus(1'b1, 8'h03, 8'hAA, 1'b0, 1'b0, rd, err, cyc);
    checks++;
    if (err !== 1'b1) begin
      failures++;
      $display("[TB] FAIL err_write_tcnt: got %b expected 1", err);
    end
    applyStimulus(1'b0, 8'h03, 8'h00, 1'b0, 1'b0, rd, err, cyc);
    checks++;
    if (rd !== 8'h3C || err !== 1'b0) begin
      failures++;
      $display("[TB] FAIL tcnt_read: rd=%h err=%b expected 3C 0", rd, err);
    end
    applyStimulus(1'b1, 8'h40, 8'h99, 1'b0, 1'b0, rd, err, cyc);
    checks++;
    if (err !== 1'b1 || tdr_o !== m_tdr) begin
      failures++;
      $display("[TB] FAIL err_high_addr: err=%b tdr=%h expected 1 %h", err, tdr_o, m_tdr);
    end
  endtask

  task automatic test_protocol();
    @(negedge pclk);
    psel = 1'b1; penable = 1'b1; pwrite = 1'b1; paddr = 8'h00; pwdata = 8'hEE;
    for (int i = 0; i < 3; i++) begin
      @(negedge pclk);
      #1;
      checks++;
      if (pready !== 1'b0) begin
        failures++;
        $display("[TB] FAIL no_setup_pready: got %b expected 0", pready);
      end
    end
    @(negedge pclk);
    psel = 1'b0; penable = 1'b0;
    @(negedge pclk);
    psel = 1'b1; penable = 1'b0; pwdata = 8'hDD;
    @(negedge pclk);
    psel = 1'b0; penable = 1'b1;
    repeat (3) @(negedge pclk);
    penable = 1'b0;
    checks++;
    if (tdr_o !== m_tdr) begin
      failures++;
      $display("[TB] FAIL abort_no_commit: got %h expected %h", tdr_o, m_tdr);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] rd; logic err; int cyc;
    time t0;
    time t1;
    applyStimulus(1'b1, 8'h00, 8'h11, 1'b0, 1'b0, rd, err, cyc);
    t0 = $time;
    applyStimulus(1'b1, 8'h00, 8'h22, 1'b0, 1'b0, rd, err, cyc);
    t1 = $time;
    checks++;
    if (t1 - t0 != 10 * (EXP_CYC + 1) || tdr_o !== 8'h22) begin
      failures++;
      $display("[TB] FAIL back_to_back: dt=%0t tdr=%h expected dt=%0d tdr=22", t1 - t0, tdr_o, 10 * (EXP_CYC + 1));
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] rd; logic err; int cyc;
    applyStimulus(1'b1, 8'h00, 8'h05, 1'b0, 1'b0, rd, err, cyc);
    @(negedge pclk);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'h00; pwdata = 8'h77;
    @(negedge pclk);
    penable = 1'b1;
    #2 preset = 1'b1;
    #1;
    checks++;
    if (pready !== 1'b0 || tdr_o !== 8'h00) begin
      failures++;
      $display("[TB] FAIL reset_mid: pready=%b tdr=%h expected 0 00", pready, tdr_o);
    end
    @(negedge pclk);
    preset = 1'b0; psel = 1'b0; penable = 1'b0;
    m_tdr = 8'h00; m_tcr = 8'h00; m_ovf = 1'b0; m_udf = 1'b0;
    repeat (2) @(negedge pclk);
    checks++;
    if (tdr_o !== 8'h00 || load_o !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_mid_hold: tdr=%h load=%b expected 00 0", tdr_o, load_o);
    end
  endtask

  task automatic test_random();
    logic [7:0] rd; logic err; int cyc;
    logic [7:0] a; logic [7:0] wd; bit wr; bit povf; bit pudf;
    logic [7:0] e_rd; bit e_err;
    for (int i = 0; i < 200; i++) begin
      a = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(4, 255)) : 8'($urandom_range(0, 3));
      wr = 1'($urandom_range(0, 1));
      wd = 8'($urandom);
      povf = ($urandom_range(0, 3) == 0);
      pudf = ($urandom_range(0, 3) == 0);
      tcnt_i = 8'($urandom);
      e_err = m_err(wr, a);
      e_rd = (wr || e_err) ? 8'h00 : m_read(a);
      applyStimulus(wr, a, wd, povf, pudf, rd, err, cyc);
      checks++;
      if (rd !== e_rd || err !== e_err || cyc != EXP_CYC) begin
        failures++;
        $display("[TB] FAIL rand_xfer[%0d] a=%h wr=%b: rd=%h err=%b cyc=%0d expected %h %b %0d",
                 i, a, wr, rd, err, cyc, e_rd, e_err, EXP_CYC);
      end
      checks++;
      if ({tdr_o, load_o, dw_o, en_o, cks_o} !== {m_tdr, m_tcr[7], m_tcr[5], m_tcr[4], m_tcr[1:0]}) begin
        failures++;
        $display("[TB] FAIL rand_ctrl[%0d]: got %h expected %h", i,
                 {tdr_o, load_o, dw_o, en_o, cks_o}, {m_tdr, m_tcr[7], m_tcr[5], m_tcr[4], m_tcr[1:0]});
      end
    end
  endtask

  initial begin
    $display("[TB] start, expected access cycles=%0d", EXP_CYC);
    test_reset();
    test_tdr();
    test_tcr();
    test_tsr();
    test_errors();
    test_protocol();
    test_back_to_back();
    test_reset_mid();
    test_random();
    bus_idle();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
